// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
// Generates the register enables, the bubble flushes and the PC write enable.
// It covers load-use stalls, taken-branch flushes, data-memory wait freezes
// with a timeout, and a debug halt that drains the pipe and then freezes it.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_RUN      | normal flow: branch flush, load-use bubble, halt entry
// S_MEM_WAIT | data memory busy, whole pipe frozen, wait counter running
// S_DRAIN    | fetch stopped, IF/ID bubbled, older stages drain out
// S_HALTED   | pipe frozen for debug until halt_req drops
// S_ERROR    | memory timeout, pipe frozen until reset
module pipeline_ctrl #(
  parameter int REG_W    = 5,
  parameter int WAIT_MAX = 15,
  parameter int WAIT_W   = 4,
  parameter int DRAIN_N  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             halt_req,
  output logic             pc_we,
  output logic             we_ifid,
  output logic             we_idex,
  output logic             we_exmem,
  output logic             we_memwb,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             halted,
  output logic             error,
  output logic [15:0]      stall_cycles
);

  localparam logic [2:0] S_RUN      = 3'd0;
  localparam logic [2:0] S_MEM_WAIT = 3'd1;
  localparam logic [2:0] S_DRAIN    = 3'd2;
  localparam logic [2:0] S_HALTED   = 3'd3;
  localparam logic [2:0] S_ERROR    = 3'd4;

  localparam int DRAIN_W = (DRAIN_N > 1) ? $clog2(DRAIN_N) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_N - 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(WAIT_MAX);

  logic [2:0]         state, state_nxt;
  logic [WAIT_W-1:0]  wait_cnt, wait_cnt_nxt;
  logic [DRAIN_W-1:0] drain_cnt, drain_cnt_nxt;
  logic               error_q, error_nxt;
  logic               load_use, mem_stall;

  assign load_use  = ex_memread && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  assign mem_stall = mem_req && !mem_ack;
  assign error     = error_q;

  // Output decode and next-state selection; reset low overrides the outputs.
  always_comb begin
    pc_we         = 1'b1;
    we_ifid       = 1'b1;
    we_idex       = 1'b1;
    we_exmem      = 1'b1;
    we_memwb      = 1'b1;
    flush_ifid    = 1'b0;
    flush_idex    = 1'b0;
    halted        = 1'b0;
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    drain_cnt_nxt = drain_cnt;
    error_nxt     = error_q;

    case (state)
      S_RUN, S_MEM_WAIT: begin
        if (mem_stall) begin
          {pc_we, we_ifid, we_idex, we_exmem, we_memwb} = 5'b0;
          if (state == S_RUN) begin
            state_nxt    = S_MEM_WAIT;
            wait_cnt_nxt = WAIT_W'(1);
          end else if (wait_cnt == WAIT_LAST) begin
            state_nxt = S_ERROR;
            error_nxt = 1'b1;
          end else begin
            wait_cnt_nxt = wait_cnt + 1'b1;
          end
        end else begin
          state_nxt = S_RUN;
          if (ex_branch_taken) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
          end else if (load_use) begin
            pc_we      = 1'b0;
            we_ifid    = 1'b0;
            flush_idex = 1'b1;
          end else if (halt_req && state == S_RUN) begin
            // a halt seen in the release cycle waits one RUN cycle
            state_nxt     = S_DRAIN;
            drain_cnt_nxt = '0;
          end
        end
      end
      S_DRAIN: begin
        if (mem_stall) begin
          {pc_we, we_ifid, we_idex, we_exmem, we_memwb} = 5'b0;
        end else begin
          pc_we      = 1'b0;
          flush_ifid = 1'b1;
        end
        if (!halt_req) begin
          state_nxt = S_RUN;
        end else if (!mem_stall) begin
          if (drain_cnt == DRAIN_LAST) state_nxt = S_HALTED;
          else drain_cnt_nxt = drain_cnt + 1'b1;
        end
      end
      S_HALTED: begin
        {pc_we, we_ifid, we_idex, we_exmem, we_memwb} = 5'b0;
        halted = 1'b1;
        if (!halt_req) state_nxt = S_RUN;
      end
      S_ERROR: begin
        {pc_we, we_ifid, we_idex, we_exmem, we_memwb} = 5'b0;
      end
      default: begin
        state_nxt = S_RUN;
      end
    endcase

    if (!reset) begin
      {pc_we, we_ifid, we_idex, we_exmem, we_memwb} = 5'b0;
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
      halted     = 1'b0;
    end
  end

  // State, counters, sticky error and saturating stall counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_RUN;
      wait_cnt     <= '0;
      drain_cnt    <= '0;
      error_q      <= 1'b0;
      stall_cycles <= 16'd0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      drain_cnt <= drain_cnt_nxt;
      error_q   <= error_nxt;
      if (!pc_we && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed scenarios plus a randomized run against a
// cycle-level behavioural model of the pipeline sequencing rules.
module tb_pipeline_ctrl;

  logic        clk, reset;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        ex_memread, ex_branch_taken, mem_req, mem_ack, halt_req;
  logic        pc_we, we_ifid, we_idex, we_exmem, we_memwb;
  logic        flush_ifid, flush_idex, halted, error;
  logic [15:0] stall_cycles;
  logic [8:0]  outs;

  int errors = 0;
  int checks = 0;

  // {pc_we, we_ifid, we_idex, we_exmem, we_memwb, flush_ifid, flush_idex, halted, error}
  localparam logic [8:0] O_DEF    = 9'b1_1111_00_0_0;
  localparam logic [8:0] O_RST    = 9'b0_0000_11_0_0;
  localparam logic [8:0] O_FREEZE = 9'b0_0000_00_0_0;
  localparam logic [8:0] O_LU     = 9'b0_0111_01_0_0;
  localparam logic [8:0] O_BR     = 9'b1_1111_11_0_0;
  localparam logic [8:0] O_DRAIN  = 9'b0_1111_10_0_0;
  localparam logic [8:0] O_HALT   = 9'b0_0000_00_1_0;
  localparam logic [8:0] O_ERR    = 9'b0_0000_00_0_1;

  pipeline_ctrl dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ack(mem_ack), .halt_req(halt_req),
    .pc_we(pc_we), .we_ifid(we_ifid), .we_idex(we_idex), .we_exmem(we_exmem),
    .we_memwb(we_memwb), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .halted(halted), .error(error), .stall_cycles(stall_cycles)
  );

  assign outs = {pc_we, we_ifid, we_idex, we_exmem, we_memwb, flush_ifid, flush_idex, halted, error};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  localparam int M_RUN = 0, M_WAIT = 1, M_DRAIN = 2, M_HALT = 3, M_ERR = 4;
  int m_mode, m_waited, m_drained, m_stalls;

  function automatic logic [8:0] model_out();
    logic lu, ms;
    lu = ex_memread && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
    ms = mem_req && !mem_ack;
    case (m_mode)
      M_RUN, M_WAIT: return ms ? O_FREEZE : ex_branch_taken ? O_BR : lu ? O_LU : O_DEF;
      M_DRAIN:       return ms ? O_FREEZE : O_DRAIN;
      M_HALT:        return O_HALT;
      default:       return O_ERR;
    endcase
  endfunction

  task automatic model_step(input logic [8:0] o);
    logic lu, ms;
    lu = ex_memread && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
    ms = mem_req && !mem_ack;
    if (!o[8]) m_stalls = (m_stalls < 65535) ? m_stalls + 1 : 65535;
    case (m_mode)
      M_RUN: begin
        if (ms) begin m_mode = M_WAIT; m_waited = 1; end
        else if (!ex_branch_taken && !lu && halt_req) begin m_mode = M_DRAIN; m_drained = 0; end
      end
      M_WAIT: begin
        if (!ms) m_mode = M_RUN;
        else if (m_waited >= 15) m_mode = M_ERR;
        else m_waited++;
      end
      M_DRAIN: begin
        if (!halt_req) m_mode = M_RUN;
        else if (!ms) begin
          m_drained++;
          if (m_drained == 3) m_mode = M_HALT;
        end
      end
      M_HALT: if (!halt_req) m_mode = M_RUN;
      default: ;
    endcase
  endtask

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; ex_rt = 0; ex_memread = 0; ex_branch_taken = 0;
    mem_req = 0; mem_ack = 0; halt_req = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    tick();
    reset = 1'b1;
    m_mode = M_RUN; m_waited = 0; m_drained = 0; m_stalls = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    halt_req = 1;
    tick(); tick();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (outs !== O_RST) begin errors++; $display("FAIL reset_forced got=%b want=%b", outs, O_RST); end
    checks++;
    if (stall_cycles !== 16'd0) begin errors++; $display("FAIL reset_stall_clr got=%0d want=0", stall_cycles); end
    tick();
    checks++;
    if (outs !== O_RST) begin errors++; $display("FAIL reset_held got=%b want=%b", outs, O_RST); end
    halt_req = 0;
    reset = 1'b1;
    #1;
    checks++;
    if (outs !== O_DEF) begin errors++; $display("FAIL reset_release got=%b want=%b", outs, O_DEF); end
    tick(); #1;
    checks++;
    if (outs !== O_DEF || stall_cycles !== 16'd0) begin
      errors++; $display("FAIL reset_run got=%b/%0d want=%b/0", outs, stall_cycles, O_DEF);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_memread = 1; ex_rt = 5; id_rs = 5; id_rt = 2;
    #1;
    checks++;
    if (outs !== O_LU) begin errors++; $display("FAIL lu_rs got=%b want=%b", outs, O_LU); end
    tick();
    ex_memread = 0;
    #1;
    checks++;
    if (outs !== O_DEF || stall_cycles !== 16'd1) begin
      errors++; $display("FAIL lu_one_bubble got=%b/%0d want=%b/1", outs, stall_cycles, O_DEF);
    end
    ex_memread = 1; ex_rt = 9; id_rs = 1; id_rt = 9;
    #1;
    checks++;
    if (outs !== O_LU) begin errors++; $display("FAIL lu_rt got=%b want=%b", outs, O_LU); end
    ex_rt = 0; id_rs = 0; id_rt = 0;
    #1;
    checks++;
    if (outs !== O_DEF) begin errors++; $display("FAIL lu_r0 got=%b want=%b", outs, O_DEF); end
  endtask

  task automatic test_branch_flush();
    do_reset();
    ex_memread = 1; ex_rt = 5; id_rs = 5; ex_branch_taken = 1;
    #1;
    checks++;
    if (outs !== O_BR) begin errors++; $display("FAIL branch_over_lu got=%b want=%b", outs, O_BR); end
    tick();
    #1;
    checks++;
    if (stall_cycles !== 16'd0) begin errors++; $display("FAIL branch_no_stall got=%0d want=0", stall_cycles); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_req = 1; mem_ack = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (outs !== O_FREEZE) begin errors++; $display("FAIL mem_freeze_%0d got=%b want=%b", i, outs, O_FREEZE); end
      tick();
    end
    mem_ack = 1;
    #1;
    checks++;
    if (outs !== O_DEF || stall_cycles !== 16'd4) begin
      errors++; $display("FAIL mem_release got=%b/%0d want=%b/4", outs, stall_cycles, O_DEF);
    end
    tick();
    mem_req = 0; mem_ack = 0;
    // halt and memory stall together: the stall wins, halt follows release
    halt_req = 1; mem_req = 1;
    #1;
    checks++;
    if (outs !== O_FREEZE) begin errors++; $display("FAIL halt_vs_mem got=%b want=%b", outs, O_FREEZE); end
    tick();
    mem_ack = 1;
    tick();
    mem_req = 0; mem_ack = 0;
    #1;
    checks++;
    if (outs !== O_DEF) begin errors++; $display("FAIL halt_after_rel got=%b want=%b", outs, O_DEF); end
    tick();
    #1;
    checks++;
    if (outs !== O_DRAIN) begin errors++; $display("FAIL halt_drain_after_mem got=%b want=%b", outs, O_DRAIN); end

    do_reset();
    mem_req = 1; mem_ack = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++;
      if (outs !== O_FREEZE) begin errors++; $display("FAIL timeout_wait_%0d got=%b want=%b", i, outs, O_FREEZE); end
      tick();
    end
    #1;
    checks++;
    if (outs !== O_ERR || stall_cycles !== 16'd16) begin
      errors++; $display("FAIL timeout_error got=%b/%0d want=%b/16", outs, stall_cycles, O_ERR);
    end
    mem_req = 0;
    tick(); tick();
    checks++;
    if (outs !== O_ERR) begin errors++; $display("FAIL error_sticky got=%b want=%b", outs, O_ERR); end
    do_reset();
    #1;
    checks++;
    if (outs !== O_DEF) begin errors++; $display("FAIL error_cleared got=%b want=%b", outs, O_DEF); end
  endtask

  task automatic test_halt();
    do_reset();
    halt_req = 1;
    #1;
    checks++;
    if (outs !== O_DEF) begin errors++; $display("FAIL halt_entry got=%b want=%b", outs, O_DEF); end
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (outs !== O_DRAIN) begin errors++; $display("FAIL drain_%0d got=%b want=%b", i, outs, O_DRAIN); end
      tick();
    end
    #1;
    checks++;
    if (outs !== O_HALT || stall_cycles !== 16'd3) begin
      errors++; $display("FAIL halted got=%b/%0d want=%b/3", outs, stall_cycles, O_HALT);
    end
    halt_req = 0;
    #1;
    checks++;
    if (outs !== O_HALT) begin errors++; $display("FAIL halted_exit_cycle got=%b want=%b", outs, O_HALT); end
    tick();
    #1;
    checks++;
    if (outs !== O_DEF || stall_cycles !== 16'd4) begin
      errors++; $display("FAIL halt_resume got=%b/%0d want=%b/4", outs, stall_cycles, O_DEF);
    end
    halt_req = 1;
    tick();
    halt_req = 0;
    #1;
    checks++;
    if (outs !== O_DRAIN) begin errors++; $display("FAIL drain_abort_cycle got=%b want=%b", outs, O_DRAIN); end
    tick();
    #1;
    checks++;
    if (outs !== O_DEF) begin errors++; $display("FAIL drain_abort got=%b want=%b", outs, O_DEF); end
  endtask

  task automatic test_saturate();
    do_reset();
    halt_req = 1;
    repeat (1000) tick();
    checks++;
    if (stall_cycles !== 16'd999) begin errors++; $display("FAIL sat_partial got=%0d want=999", stall_cycles); end
    repeat (64540) tick();
    checks++;
    if (stall_cycles !== 16'hFFFF) begin errors++; $display("FAIL sat_max got=%h want=ffff", stall_cycles); end
    halt_req = 0;
    tick();
    #1;
    checks++;
    if (outs !== O_DEF || stall_cycles !== 16'hFFFF) begin
      errors++; $display("FAIL sat_hold got=%b/%h want=%b/ffff", outs, stall_cycles, O_DEF);
    end
  endtask

  task automatic test_random();
    logic [8:0] exp;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      id_rs           = 5'($urandom_range(0, 7));
      id_rt           = 5'($urandom_range(0, 7));
      ex_rt           = 5'($urandom_range(0, 7));
      ex_memread      = ($urandom_range(0, 9) < 3);
      ex_branch_taken = ($urandom_range(0, 19) < 3);
      mem_req         = ($urandom_range(0, 3) == 0) || (m_mode == M_WAIT && $urandom_range(0, 9) < 8);
      mem_ack         = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 19) == 0) halt_req = !halt_req;
      #1;
      exp = model_out();
      checks++;
      if (outs !== exp || stall_cycles !== 16'(m_stalls)) begin
        errors++;
        $display("FAIL random_%0d got=%b/%0d want=%b/%0d", n, outs, stall_cycles, exp, m_stalls);
      end
      model_step(exp);
      tick();
      if (m_mode == M_ERR && $urandom_range(0, 3) == 0) do_reset();
    end
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    test_reset();
    test_load_use();
    test_branch_flush();
    test_mem_wait();
    test_halt();
    test_random();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
